// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: pipeline typedefs and constants shared by the write-back register file
package wb_regfile_pkg;
  localparam int DATA_W = 8;
  localparam int RF_ADRS_W = 4;
  localparam int NREGS = 2 ** RF_ADRS_W;
  typedef logic [DATA_W-1:0] t_data;
  typedef logic [RF_ADRS_W-1:0] t_RFadrs;
  typedef logic [RF_ADRS_W:0] t_cnt;
  typedef logic [NREGS-1:0] t_mask;
  function automatic t_cnt popcount(input t_mask v);
    t_cnt c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c += t_cnt'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: WB write, issue and decode read signals of the register file
interface wb_regfile_if;
  import wb_regfile_pkg::*;
  logic wr_en;
  t_RFadrs dst;
  t_data data_in;
  logic issue_en;
  t_RFadrs issue_dst;
  t_RFadrs rd_adrs_a;
  t_RFadrs rd_adrs_b;
  t_data rd_data_a;
  t_data rd_data_b;
  logic pending_a;
  logic pending_b;
  t_cnt pending_cnt;
  modport master (
    output wr_en, dst, data_in, issue_en, issue_dst, rd_adrs_a, rd_adrs_b,
    input rd_data_a, rd_data_b, pending_a, pending_b, pending_cnt
  );
  modport slave (
    input wr_en, dst, data_in, issue_en, issue_dst, rd_adrs_a, rd_adrs_b,
    output rd_data_a, rd_data_b, pending_a, pending_b, pending_cnt
  );
endinterface

// File: rtl/wb_regfile_rf_scoreboard.sv
// rf_scoreboard: per-register pending bits with set-over-clear priority and a registered population count
module rf_scoreboard
  import wb_regfile_pkg::*;
(
  input  logic    clock,
  input  logic    rst_n,
  input  logic    set_en,
  input  t_RFadrs set_adrs,
  input  logic    clr_en,
  input  t_RFadrs clr_adrs,
  output t_mask   pend,
  output t_cnt    cnt
);
  t_mask set_mask, clr_mask, nxt;
  always_comb begin
    set_mask = set_en ? t_mask'(1) << set_adrs : '0;
    clr_mask = clr_en ? t_mask'(1) << clr_adrs : '0;
    nxt = (pend & ~clr_mask) | set_mask;
  end
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      pend <= '0;
      cnt <= '0;
    end else begin
      pend <= nxt;
      cnt <= popcount(nxt);
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back register file with bypassed dual read ports and a pending-write scoreboard
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic clock,
  input logic rst_n,
  wb_regfile_if.slave bus
);
  t_data regs [NREGS];
  t_mask pend;
  logic hit_a, hit_b;
  always_ff @(posedge clock) begin
    if (!rst_n) regs <= '{default: '0};
    else if (bus.wr_en) regs[bus.dst] <= bus.data_in;
  end
  rf_scoreboard u_sb (
    .clock(clock),
    .rst_n(rst_n),
    .set_en(bus.issue_en),
    .set_adrs(bus.issue_dst),
    .clr_en(bus.wr_en),
    .clr_adrs(bus.dst),
    .pend(pend),
    .cnt(bus.pending_cnt)
  );
  always_comb begin
    hit_a = bus.wr_en && bus.dst == bus.rd_adrs_a;
    hit_b = bus.wr_en && bus.dst == bus.rd_adrs_b;
    bus.rd_data_a = hit_a ? bus.data_in : regs[bus.rd_adrs_a];
    bus.rd_data_b = hit_b ? bus.data_in : regs[bus.rd_adrs_b];
    bus.pending_a = pend[bus.rd_adrs_a] && !hit_a;
    bus.pending_b = pend[bus.rd_adrs_b] && !hit_b;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scoreboard bench for wb_regfile
module tb_wb_regfile;
  logic clock = 0;
  logic rst_n = 0;
  int passed = 0;
  int total = 0;
  typedef struct {
    string tag;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];
  wb_regfile_if bus();
  wb_regfile dut (.clock(clock), .rst_n(rst_n), .bus(bus.slave));
  always #5 clock = ~clock;
  task automatic expect_v(input string t, input logic [15:0] v);
    exp_t e;
    e.tag = t;
    e.v = v;
    q.push_back(e);
  endtask
  task automatic observe(input logic [15:0] o);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      $error("FAIL queue_empty observed=%0h required=entry", o);
      return;
    end
    e = q.pop_front();
    assert (o === e.v) passed++;
    else $error("FAIL %s observed=%0h required=%0h", e.tag, o, e.v);
  endtask
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic drive(input logic we, input logic [3:0] d, input logic [7:0] di,
                       input logic ie, input logic [3:0] id, input logic [3:0] ra, input logic [3:0] rb);
    bus.wr_en = we;
    bus.dst = d;
    bus.data_in = di;
    bus.issue_en = ie;
    bus.issue_dst = id;
    bus.rd_adrs_a = ra;
    bus.rd_adrs_b = rb;
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 3, 9);
    expect_v("rst_cnt", 0); observe(16'(bus.pending_cnt));
    expect_v("rst_rd_b", 0); observe(16'(bus.rd_data_b));
    expect_v("rst_pend_a", 0); observe(16'(bus.pending_a));
    drive(1, 3, 8'h5A, 0, 0, 3, 3);
    step();
    drive(0, 0, 0, 0, 0, 3, 3);
    expect_v("wr3_rd_a", 16'h5A); observe(16'(bus.rd_data_a));
    rst_n = 0;
    step();
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 3, 3);
    expect_v("rst3_rd_a", 0); observe(16'(bus.rd_data_a));
    expect_v("rst3_cnt", 0); observe(16'(bus.pending_cnt));
    drive(1, 7, 8'hC3, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 7, 6);
    expect_v("wr7_rd_a", 16'hC3); observe(16'(bus.rd_data_a));
    expect_v("rd6_rd_b", 0); observe(16'(bus.rd_data_b));
    drive(1, 2, 8'h11, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 2, 2);
    expect_v("reg2_pre", 16'h11); observe(16'(bus.rd_data_a));
    drive(1, 2, 8'h22, 0, 0, 2, 2);
    expect_v("byp_rd_a", 16'h22); observe(16'(bus.rd_data_a));
    expect_v("byp_rd_b", 16'h22); observe(16'(bus.rd_data_b));
    step();
    drive(0, 0, 0, 0, 0, 2, 2);
    expect_v("reg2_post", 16'h22); observe(16'(bus.rd_data_a));
    drive(0, 0, 0, 1, 5, 5, 5);
    expect_v("sb_c0_pend", 0); observe(16'(bus.pending_a));
    expect_v("sb_c0_cnt", 0); observe(16'(bus.pending_cnt));
    step();
    drive(0, 0, 0, 0, 0, 5, 5);
    expect_v("sb_c1_pend_a", 1); observe(16'(bus.pending_a));
    expect_v("sb_c1_pend_b", 1); observe(16'(bus.pending_b));
    expect_v("sb_c1_cnt", 1); observe(16'(bus.pending_cnt));
    step();
    drive(1, 5, 8'h55, 0, 0, 5, 5);
    expect_v("sb_c2_pend", 0); observe(16'(bus.pending_a));
    expect_v("sb_c2_cnt", 1); observe(16'(bus.pending_cnt));
    step();
    drive(0, 0, 0, 0, 0, 5, 5);
    expect_v("sb_c3_pend", 0); observe(16'(bus.pending_a));
    expect_v("sb_c3_cnt", 0); observe(16'(bus.pending_cnt));
    drive(0, 0, 0, 1, 4, 4, 4);
    step();
    drive(1, 4, 8'h44, 1, 4, 4, 4);
    step();
    drive(0, 0, 0, 0, 0, 4, 4);
    expect_v("sc_pend4", 1); observe(16'(bus.pending_a));
    expect_v("sc_cnt", 1); observe(16'(bus.pending_cnt));
    expect_v("sc_reg4", 16'h44); observe(16'(bus.rd_data_a));
    drive(0, 0, 0, 1, 8, 8, 9);
    step();
    drive(0, 0, 0, 1, 9, 8, 9);
    step();
    drive(0, 0, 0, 1, 9, 8, 9);
    step();
    drive(1, 10, 8'hA0, 0, 0, 8, 9);
    expect_v("multi_cnt", 3); observe(16'(bus.pending_cnt));
    expect_v("multi_pend_b", 1); observe(16'(bus.pending_b));
    step();
    drive(0, 0, 0, 0, 0, 10, 9);
    expect_v("nopend_wr_cnt", 3); observe(16'(bus.pending_cnt));
    expect_v("nopend_wr_rd", 16'hA0); observe(16'(bus.rd_data_a));
    rst_n = 0;
    drive(1, 1, 8'hFF, 1, 1, 1, 1);
    step();
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 1, 8);
    expect_v("rp_reg1", 0); observe(16'(bus.rd_data_a));
    expect_v("rp_pend1", 0); observe(16'(bus.pending_a));
    expect_v("rp_pend8", 0); observe(16'(bus.pending_b));
    expect_v("rp_cnt", 0); observe(16'(bus.pending_cnt));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
